// File: rtl/vector_sum_arb_if.sv
// Handshake bundle for vector_sum_arb: per-requester word streams in, one frame result out.
// master is the requester/consumer side, slave is the arbiter.
interface vector_sum_arb_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 10,
  parameter int unsigned MAXW   = 16
);
  localparam int unsigned POS_W = $clog2(DATA_W);
  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(MAXW + 1);
  localparam int unsigned ACC_W = POS_W + 1 + $clog2(MAXW);

  logic [NREQ-1:0]        in_valid;
  logic [NREQ-1:0]        in_ready;
  logic [NREQ*DATA_W-1:0] in_data;
  logic [NREQ-1:0]        in_last;

  logic                   out_valid;
  logic                   out_ready;
  logic [ID_W-1:0]        out_id;
  logic [ACC_W-1:0]       out_sum;
  logic [CNT_W-1:0]       out_words;
  logic                   out_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_id, out_sum, out_words, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_id, out_sum, out_words, out_err
  );
endinterface

// File: rtl/vector_sum_arb.sv
// Frame-granular round-robin arbiter in front of a shared popcount accumulator.
// A granted requester owns the datapath until its last word; the result is held until consumed.
module vector_sum_arb #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned MAXW   = 16
) (
  input  logic             clk,
  input  logic             rst,
  vector_sum_arb_if.slave  bus
);
  localparam int unsigned POS_W = $clog2(DATA_W);
  localparam int unsigned PC_W  = POS_W + 1;
  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(MAXW + 1);
  localparam int unsigned ACC_W = POS_W + 1 + $clog2(MAXW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic               err_q, err_d;

  logic [ID_W-1:0]    winner_c;
  logic               found_c;
  logic [ID_W-1:0]    sel_c;
  logic [DATA_W-1:0]  word_c;
  logic [PC_W-1:0]    pc_w_c;
  logic [ACC_W-1:0]   pc_c;
  logic [NREQ-1:0]    in_ready_c;

  // Round-robin search starting just after the previous owner
  always_comb begin
    winner_c = '0;
    found_c  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!found_c && bus.in_valid[ID_W'((32'(ptr_q) + k) % NREQ)]) begin
        winner_c = ID_W'((32'(ptr_q) + k) % NREQ);
        found_c  = 1'b1;
      end
    end
  end

  // Only the granted lane feeds the popcount: the winner while idle, the owner afterwards
  always_comb begin
    sel_c  = (state_q == ST_IDLE) ? winner_c : owner_q;
    word_c = bus.in_data[32'(sel_c)*DATA_W +: DATA_W];
    pc_w_c = '0;
    for (int unsigned b = 0; b < DATA_W; b++) begin
      pc_w_c = pc_w_c + PC_W'(word_c[b]);
    end
    pc_c = ACC_W'(pc_w_c);
  end

  // Next-state and accumulation
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    acc_d      = acc_q;
    words_d    = words_q;
    err_d      = err_q;
    in_ready_c = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          in_ready_c[winner_c] = 1'b1;
          owner_d = winner_c;
          acc_d   = pc_c;
          words_d = CNT_W'(1);
          err_d   = 1'b0;
          state_d = bus.in_last[winner_c] ? ST_DONE : ST_LOCK;
        end
      end

      ST_LOCK: begin
        in_ready_c[owner_q] = 1'b1;
        if (bus.in_valid[owner_q]) begin
          // Words past MAXW are drained so the requester can finish, but not counted
          if (words_q < CNT_W'(MAXW)) begin
            acc_d   = acc_q + pc_c;
            words_d = words_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
          if (bus.in_last[owner_q]) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          ptr_d   = owner_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= ID_W'(NREQ - 1);
      owner_q <= '0;
      acc_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      acc_q   <= acc_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_id    = owner_q;
  assign bus.out_sum   = acc_q;
  assign bus.out_words = words_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_vector_sum_arb.sv
// Scenario bench for vector_sum_arb: expected frame results are queued as frames are sent
// and popped when the arbiter presents them.
module tb_vector_sum_arb;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned MAXW   = 16;

  typedef struct packed {
    logic [1:0] id;
    logic [8:0] sum;
    logic [4:0] words;
    logic       err;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  res_t sb[$];
  res_t got;
  res_t exp_r;

  vector_sum_arb_if #(.NREQ(NREQ), .DATA_W(DATA_W), .MAXW(MAXW)) bus ();

  vector_sum_arb #(.DATA_W(DATA_W), .NREQ(NREQ), .MAXW(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  function automatic res_t mk(input int id, input int sum, input int words, input logic err);
    res_t r;
    r.id    = 2'(id);
    r.sum   = 9'(sum);
    r.words = 5'(words);
    r.err   = err;
    return r;
  endfunction

  function automatic res_t get_res();
    res_t r;
    r.id    = bus.out_id;
    r.sum   = bus.out_sum;
    r.words = bus.out_words;
    r.err   = bus.out_err;
    return r;
  endfunction

  // Presents one word on lane r and returns at the negedge after it has been accepted
  task automatic send_word(input int r, input logic [DATA_W-1:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    bus.in_valid[r] = 1'b1;
    bus.in_data[r*DATA_W +: DATA_W] = d;
    bus.in_last[r] = l;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (bus.in_ready[r] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.in_valid[r] = 1'b0;
    bus.in_last[r]  = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_word req%0d: in_ready got 0 expected 1 within 64 cycles", r);
    end
  endtask

  task automatic wait_valid(input string tag);
    int c;
    c = 0;
    while (bus.out_valid !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s wait: out_valid got %b expected 1 within 100 cycles", tag, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset ctl: in_ready=%b out_valid=%b expected 0000/0", bus.in_ready, bus.out_valid);
    end
    got = get_res();
    checks++;
    if (got !== mk(0, 0, 0, 1'b0)) begin
      errors++;
      $display("FAIL reset outs: got id=%0d sum=%0d words=%0d err=%0d expected all 0",
               got.id, got.sum, got.words, got.err);
    end
    rst = 1'b0;
    @(negedge clk);
    bus.in_valid = 4'b1111;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset priority: in_ready=%b expected 0001", bus.in_ready);
    end
    bus.in_valid = 4'b0000;
    bus.in_last[2] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL last_no_valid: out_valid=%b in_ready=%b expected 0/0000", bus.out_valid, bus.in_ready);
    end
    bus.in_last[2] = 1'b0;
  endtask

  task automatic test_single();
    sb.push_back(mk(0, 6, 1, 1'b0));
    send_word(0, 10'b1111000011, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single latency: out_valid=%b in_ready=%b expected 1/0000", bus.out_valid, bus.in_ready);
    end
    wait_valid("single");
    got = get_res();
    exp_r = sb.pop_front();
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL single result: got id=%0d sum=%0d words=%0d err=%0d expected id=%0d sum=%0d words=%0d err=%0d",
               got.id, got.sum, got.words, got.err, exp_r.id, exp_r.sum, exp_r.words, exp_r.err);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single release: out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_lock();
    sb.push_back(mk(2, 11, 3, 1'b0));
    send_word(2, 10'h3FF, 1'b0);
    bus.in_valid[1] = 1'b1;
    bus.in_data[1*DATA_W +: DATA_W] = 10'h001;
    bus.in_last[1] = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL lock grant: in_ready=%b expected 0100", bus.in_ready);
    end
    send_word(2, 10'h001, 1'b0);
    checks++;
    if (bus.in_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL lock stall: in_ready[1]=%b expected 0", bus.in_ready[1]);
    end
    send_word(2, 10'h000, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL lock done: out_valid=%b in_ready=%b expected 1/0000", bus.out_valid, bus.in_ready);
    end
    wait_valid("lock");
    got = get_res();
    exp_r = sb.pop_front();
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL lock result: got id=%0d sum=%0d words=%0d err=%0d expected id=%0d sum=%0d words=%0d err=%0d",
               got.id, got.sum, got.words, got.err, exp_r.id, exp_r.sum, exp_r.words, exp_r.err);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL lock handoff: in_ready=%b expected 0010", bus.in_ready);
    end
    sb.push_back(mk(1, 1, 1, 1'b0));
    send_word(1, 10'h001, 1'b1);
    wait_valid("handoff");
    got = get_res();
    exp_r = sb.pop_front();
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL handoff result: got id=%0d sum=%0d words=%0d err=%0d expected id=%0d sum=%0d words=%0d err=%0d",
               got.id, got.sum, got.words, got.err, exp_r.id, exp_r.sum, exp_r.words, exp_r.err);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus.in_data[r*DATA_W +: DATA_W] = 10'h001;
    end
    bus.in_last  = 4'b1111;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_rdy = 4'b0001 << (i % 4);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr grant%0d: in_ready=%b expected %b", i, bus.in_ready, exp_rdy);
      end
      sb.push_back(mk(i % 4, 1, 1, 1'b0));
      @(negedge clk);
      if (i == 4) begin
        bus.in_valid = 4'b0000;
        bus.in_last  = 4'b0000;
      end
      wait_valid("rr");
      got = get_res();
      exp_r = sb.pop_front();
      checks++;
      if (got !== exp_r) begin
        errors++;
        $display("FAIL rr result%0d: got id=%0d sum=%0d words=%0d err=%0d expected id=%0d sum=%0d words=%0d err=%0d",
                 i, got.id, got.sum, got.words, got.err, exp_r.id, exp_r.sum, exp_r.words, exp_r.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    sb.push_back(mk(3, 10, 1, 1'b0));
    send_word(3, 10'h3FF, 1'b1);
    bus.in_valid[0] = 1'b1;
    bus.in_data[0*DATA_W +: DATA_W] = 10'h155;
    bus.in_last[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      got = get_res();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 4'b0000 || got !== sb[0]) begin
        errors++;
        $display("FAIL backpressure hold%0d: out_valid=%b in_ready=%b sum=%0d expected 1/0000/%0d",
                 c, bus.out_valid, bus.in_ready, got.sum, sb[0].sum);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    got = get_res();
    exp_r = sb.pop_front();
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL backpressure result: got id=%0d sum=%0d words=%0d err=%0d expected id=%0d sum=%0d words=%0d err=%0d",
               got.id, got.sum, got.words, got.err, exp_r.id, exp_r.sum, exp_r.words, exp_r.err);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure restart: in_ready=%b out_valid=%b expected 0001/0", bus.in_ready, bus.out_valid);
    end
    sb.push_back(mk(0, 5, 1, 1'b0));
    send_word(0, 10'h155, 1'b1);
    wait_valid("restart");
    got = get_res();
    exp_r = sb.pop_front();
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL restart result: got id=%0d sum=%0d words=%0d err=%0d expected id=%0d sum=%0d words=%0d err=%0d",
               got.id, got.sum, got.words, got.err, exp_r.id, exp_r.sum, exp_r.words, exp_r.err);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    sb.push_back(mk(1, 160, 16, 1'b1));
    for (int w = 0; w < 18; w++) begin
      send_word(1, 10'h3FF, (w == 17));
    end
    wait_valid("overflow");
    got = get_res();
    exp_r = sb.pop_front();
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL overflow result: got id=%0d sum=%0d words=%0d err=%0d expected id=%0d sum=%0d words=%0d err=%0d",
               got.id, got.sum, got.words, got.err, exp_r.id, exp_r.sum, exp_r.words, exp_r.err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    send_word(3, 10'h001, 1'b0);
    send_word(3, 10'h001, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      got = get_res();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000 || got !== mk(0, 0, 0, 1'b0)) begin
        errors++;
        $display("FAIL reset_mid idle: out_valid=%b in_ready=%b sum=%0d words=%0d expected 0/0000/0/0",
                 bus.out_valid, bus.in_ready, got.sum, got.words);
      end
      @(negedge clk);
    end
    bus.in_valid[0] = 1'b1;
    bus.in_valid[3] = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid priority: in_ready=%b expected 0001", bus.in_ready);
    end
    bus.in_valid[0] = 1'b0;
    sb.push_back(mk(3, 4, 4, 1'b0));
    for (int w = 0; w < 4; w++) begin
      send_word(3, 10'h001, (w == 3));
      if (w < 3) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid early: out_valid=%b expected 0 after word %0d", bus.out_valid, w);
        end
      end
    end
    wait_valid("reset_mid");
    got = get_res();
    exp_r = sb.pop_front();
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL reset_mid result: got id=%0d sum=%0d words=%0d err=%0d expected id=%0d sum=%0d words=%0d err=%0d",
               got.id, got.sum, got.words, got.err, exp_r.id, exp_r.sum, exp_r.words, exp_r.err);
    end
    @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.in_last   = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_lock();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d results left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
